// File: rtl/div_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : div_issue_ctrl
// Description : In-order issue controller for the iterative divider. Queues
//               divide ops from decode, issues one at a time, buffers the
//               result for writeback, handles flush and rd-pending queries.
// Revision    : 1.0 - initial release
// ============================================================================
module div_issue_ctrl #(
  parameter int DEPTH = 2,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_rs1,
  input  logic [31:0]      req_rs2,
  input  logic [4:0]       req_rd,
  input  logic             req_unsign,
  input  logic             req_rem,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic             div_issue,
  output logic [31:0]      div_rs1,
  output logic [31:0]      div_rs2,
  output logic             div_unsign,
  output logic             div_rem,
  output logic [4:0]       div_rd,
  output logic             div_flush,
  input  logic             div_out_valid,
  input  logic [31:0]      div_result,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [31:0]      wb_data,
  output logic [4:0]       wb_rd,
  output logic [TAG_W-1:0] wb_tag,
  input  logic [4:0]       query_rd,
  output logic             query_hit,
  output logic             busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_WB    = 2'd3;

  // Queue storage (data only, no reset needed; validity comes from the counter)
  logic [31:0]      rs1_mem_q [DEPTH];
  logic [31:0]      rs2_mem_q [DEPTH];
  logic [4:0]       rd_mem_q  [DEPTH];
  logic             uns_mem_q [DEPTH];
  logic             rem_mem_q [DEPTH];
  logic [TAG_W-1:0] tag_mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       state_q, state_d;
  logic             flush_q;
  logic [4:0]       infl_rd_q;
  logic [TAG_W-1:0] infl_tag_q;
  logic [31:0]      wb_data_q;
  logic [4:0]       wb_rd_q;
  logic [TAG_W-1:0] wb_tag_q;

  logic w_full, w_empty, w_push, w_pop, w_capture;
  logic [DEPTH-1:0] w_q_match;

  assign w_full    = (cnt_q == CNT_W'(DEPTH));
  assign w_empty   = (cnt_q == '0);
  assign req_ready = ~w_full & ~flush;
  assign w_push    = req_valid & req_ready;
  assign div_issue = (state_q == S_ISSUE) & ~flush;
  assign w_pop     = div_issue;
  assign w_capture = (state_q == S_RUN) & div_out_valid & ~flush;

  // Operand fields are only meaningful with the issue pulse; hold 0 otherwise
  assign div_rs1    = div_issue ? rs1_mem_q[rd_ptr_q] : '0;
  assign div_rs2    = div_issue ? rs2_mem_q[rd_ptr_q] : '0;
  assign div_rd     = div_issue ? rd_mem_q[rd_ptr_q]  : '0;
  assign div_unsign = div_issue & uns_mem_q[rd_ptr_q];
  assign div_rem    = div_issue & rem_mem_q[rd_ptr_q];

  // Flush to the divider spans the flush cycle and the one after it
  assign div_flush = (flush | flush_q) & ~rst;

  assign wb_valid = (state_q == S_WB);
  assign wb_data  = wb_valid ? wb_data_q : '0;
  assign wb_rd    = wb_valid ? wb_rd_q   : '0;
  assign wb_tag   = wb_valid ? wb_tag_q  : '0;

  assign busy = ~w_empty | (state_q != S_IDLE);

  // Per-entry pending-rd match; an entry is live if its distance from the head is below the count
  for (genvar i = 0; i < DEPTH; i++) begin : g_qmatch
    logic [PTR_W-1:0] w_off;
    assign w_off        = PTR_W'(i) - rd_ptr_q;
    assign w_q_match[i] = ({1'b0, w_off} < cnt_q) && (rd_mem_q[i] == query_rd);
  end

  // Pending-rd lookup across queue, inflight op and writeback buffer
  always_comb begin
    query_hit = 1'b0;
    if (query_rd != 5'd0) begin
      query_hit = (|w_q_match)
                | ((state_q == S_RUN) && (infl_rd_q == query_rd))
                | ((state_q == S_WB)  && (wb_rd_q   == query_rd));
    end
  end

  // Next-state logic for the issue sequencer
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if ((~w_empty | w_push) & ~flush) state_d = S_ISSUE;
      S_ISSUE: state_d = flush ? S_IDLE : S_RUN;
      S_RUN:   if (flush) state_d = S_IDLE;
               else if (div_out_valid) state_d = S_WB;
      S_WB:    if (flush | wb_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Queue entry writes
  always_ff @(posedge clk) begin
    if (w_push) begin
      rs1_mem_q[wr_ptr_q] <= req_rs1;
      rs2_mem_q[wr_ptr_q] <= req_rs2;
      rd_mem_q[wr_ptr_q]  <= req_rd;
      uns_mem_q[wr_ptr_q] <= req_unsign;
      rem_mem_q[wr_ptr_q] <= req_rem;
      tag_mem_q[wr_ptr_q] <= req_tag;
    end
  end

  // Queue pointers/occupancy, FSM, inflight and writeback registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      state_q    <= S_IDLE;
      flush_q    <= 1'b0;
      infl_rd_q  <= '0;
      infl_tag_q <= '0;
      wb_data_q  <= '0;
      wb_rd_q    <= '0;
      wb_tag_q   <= '0;
    end else begin
      state_q <= state_d;
      flush_q <= flush;
      if (flush) begin
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        cnt_q      <= '0;
        infl_rd_q  <= '0;
        infl_tag_q <= '0;
        wb_data_q  <= '0;
        wb_rd_q    <= '0;
        wb_tag_q   <= '0;
      end else begin
        if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        if (w_push & ~w_pop)      cnt_q <= cnt_q + 1'b1;
        else if (~w_push & w_pop) cnt_q <= cnt_q - 1'b1;
        if (w_pop) begin
          infl_rd_q  <= rd_mem_q[rd_ptr_q];
          infl_tag_q <= tag_mem_q[rd_ptr_q];
        end
        if (w_capture) begin
          wb_data_q <= div_result;
          wb_rd_q   <= infl_rd_q;
          wb_tag_q  <= infl_tag_q;
        end
      end
    end
  end

`ifdef ASSERT_ON
  // A divider result is only expected while waiting in RUN (flush window excepted)
  always @(posedge clk) begin
    if (!rst && !div_flush)
      assert (!(div_out_valid && state_q != S_RUN))
        else $error("div_out_valid outside RUN");
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_div_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_issue_ctrl
// Description : Directed self-checking bench for div_issue_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_issue_ctrl;

  logic        clk, rst;
  logic        req_valid, req_ready;
  logic [31:0] req_rs1, req_rs2;
  logic [4:0]  req_rd;
  logic        req_unsign, req_rem;
  logic [31:0] req_tag;
  logic        flush;
  logic        div_issue;
  logic [31:0] div_rs1, div_rs2;
  logic        div_unsign, div_rem;
  logic [4:0]  div_rd;
  logic        div_flush;
  logic        div_out_valid;
  logic [31:0] div_result;
  logic        wb_valid, wb_ready;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic [31:0] wb_tag;
  logic [4:0]  query_rd;
  logic        query_hit, busy;

  int checks   = 0;
  int failures = 0;

  div_issue_ctrl #(.DEPTH(2), .TAG_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
    .req_unsign(req_unsign), .req_rem(req_rem), .req_tag(req_tag),
    .flush(flush),
    .div_issue(div_issue), .div_rs1(div_rs1), .div_rs2(div_rs2),
    .div_unsign(div_unsign), .div_rem(div_rem), .div_rd(div_rd),
    .div_flush(div_flush),
    .div_out_valid(div_out_valid), .div_result(div_result),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
    .wb_rd(wb_rd), .wb_tag(wb_tag),
    .query_rd(query_rd), .query_hit(query_hit), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [31:0] rs1, input logic [31:0] rs2, input logic [4:0] rd,
                     input logic [31:0] tag);
    req_valid = 1'b1; req_rs1 = rs1; req_rs2 = rs2; req_rd = rd; req_tag = tag;
  endtask

  // Wait (bounded) for an issue, check it, return a result and accept the writeback
  task automatic run_op(input logic [31:0] rs1, input logic [31:0] tag, input logic [31:0] res);
    int n = 0;
    #1;
    while (!div_issue && n < 20) begin
      tick(); #1; n++;
    end
    chk1("run_issue_seen", div_issue, 1'b1);
    chk32("run_issue_rs1", div_rs1, rs1);
    tick();
    div_out_valid = 1'b1; div_result = res;
    tick();
    div_out_valid = 1'b0; #1;
    chk1("run_wb_valid", wb_valid, 1'b1);
    chk32("run_wb_tag", wb_tag, tag);
    chk32("run_wb_data", wb_data, res);
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_rs1 = '0; req_rs2 = '0; req_rd = '0;
    req_unsign = 1'b0; req_rem = 1'b0; req_tag = '0; flush = 1'b0;
    div_out_valid = 1'b0; div_result = '0; wb_ready = 1'b0; query_rd = '0;

    // Reset state
    tick(); tick(); #1;
    chk1("rst_req_ready", req_ready, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_wb_valid", wb_valid, 1'b0);
    chk1("rst_div_issue", div_issue, 1'b0);
    chk1("rst_div_flush", div_flush, 1'b0);
    tick();
    rst = 1'b0;
    tick();

    // Single op: 100/7 -> 14, with writeback backpressure
    req(32'd100, 32'd7, 5'd5, 32'hA1); query_rd = 5'd5; #1;
    chk1("t1_ready", req_ready, 1'b1);
    chk1("t1_no_issue_yet", div_issue, 1'b0);
    tick();
    req_valid = 1'b0; #1;
    chk1("t1_issue", div_issue, 1'b1);
    chk32("t1_rs1", div_rs1, 32'd100);
    chk32("t1_rs2", div_rs2, 32'd7);
    chk32("t1_rd", 32'(div_rd), 32'd5);
    chk1("t1_rem", div_rem, 1'b0);
    chk1("t1_qhit_issue", query_hit, 1'b1);
    tick(); #1;
    chk1("t1_issue_pulse_end", div_issue, 1'b0);
    chk1("t1_busy_run", busy, 1'b1);
    chk1("t1_qhit_run", query_hit, 1'b1);
    tick();
    div_out_valid = 1'b1; div_result = 32'd14; #1;
    chk1("t1_wb_not_yet", wb_valid, 1'b0);
    tick();
    div_out_valid = 1'b0; div_result = 32'hFFFF; #1;
    chk1("t1_wb_valid", wb_valid, 1'b1);
    chk32("t1_wb_data", wb_data, 32'd14);
    chk32("t1_wb_rd", 32'(wb_rd), 32'd5);
    chk32("t1_wb_tag", wb_tag, 32'hA1);
    for (int i = 0; i < 10; i++) begin
      tick(); #1;
      chk1("t1_hold_valid", wb_valid, 1'b1);
      chk32("t1_hold_data", wb_data, 32'd14);
      chk32("t1_hold_tag", wb_tag, 32'hA1);
      chk1("t1_hold_no_issue", div_issue, 1'b0);
      chk1("t1_hold_qhit", query_hit, 1'b1);
    end
    tick();
    wb_ready = 1'b1; #1;
    chk1("t1_accept_cycle_valid", wb_valid, 1'b1);
    tick();
    wb_ready = 1'b0; #1;
    chk1("t1_after_accept_valid", wb_valid, 1'b0);
    chk1("t1_after_accept_busy", busy, 1'b0);
    chk1("t1_after_accept_qhit", query_hit, 1'b0);
    tick();

    // Queue full with DEPTH=2, in-order issue
    req(32'd10, 32'd3, 5'd1, 32'h11); req_unsign = 1'b1; req_rem = 1'b1; #1;
    chk1("t2_ready_a", req_ready, 1'b1);
    tick();
    req(32'd20, 32'd4, 5'd2, 32'h22); req_unsign = 1'b0; req_rem = 1'b0; #1;
    chk1("t2_issue_a", div_issue, 1'b1);
    chk32("t2_issue_a_rs1", div_rs1, 32'd10);
    chk1("t2_issue_a_uns", div_unsign, 1'b1);
    chk1("t2_issue_a_rem", div_rem, 1'b1);
    chk1("t2_ready_b", req_ready, 1'b1);
    tick();
    req(32'd30, 32'd5, 5'd3, 32'h33); #1;
    chk1("t2_ready_c", req_ready, 1'b1);
    tick();
    req(32'd40, 32'd6, 5'd4, 32'h44);
    div_out_valid = 1'b1; div_result = 32'd3; #1;
    chk1("t2_full_ready", req_ready, 1'b0);
    tick();
    div_out_valid = 1'b0; wb_ready = 1'b1; #1;
    chk1("t2_wb_a_valid", wb_valid, 1'b1);
    chk32("t2_wb_a_tag", wb_tag, 32'h11);
    chk32("t2_wb_a_data", wb_data, 32'd3);
    chk1("t2_full_ready_wb", req_ready, 1'b0);
    tick();
    wb_ready = 1'b0; #1;
    chk1("t2_idle_no_issue", div_issue, 1'b0);
    tick(); #1;
    chk1("t2_issue_b", div_issue, 1'b1);
    chk32("t2_issue_b_rs1", div_rs1, 32'd20);
    chk1("t2_full_pop_ready", req_ready, 1'b0);
    tick(); #1;
    chk1("t2_ready_after_pop", req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
    div_out_valid = 1'b1; div_result = 32'h222;
    tick();
    div_out_valid = 1'b0; #1;
    chk32("t2_wb_b_tag", wb_tag, 32'h22);
    chk32("t2_wb_b_data", wb_data, 32'h222);
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    run_op(32'd30, 32'h33, 32'h333);
    run_op(32'd40, 32'h44, 32'h444);
    #1;
    chk1("t2_drained_busy", busy, 1'b0);
    tick();

    // Flush in RUN with one queued op
    req(32'd70, 32'd2, 5'd7, 32'h55);
    tick();
    req(32'd90, 32'd2, 5'd9, 32'h66); #1;
    chk1("t3_issue_e", div_issue, 1'b1);
    tick();
    req_valid = 1'b0; flush = 1'b1; div_out_valid = 1'b1; div_result = 32'hDEAD;
    query_rd = 5'd9; #1;
    chk1("t3_flush_c0", div_flush, 1'b1);
    chk1("t3_flush_ready", req_ready, 1'b0);
    chk1("t3_qhit_before", query_hit, 1'b1);
    tick();
    flush = 1'b0; #1;
    chk1("t3_flush_c1", div_flush, 1'b1);
    chk1("t3_busy_after", busy, 1'b0);
    chk1("t3_no_wb_c1", wb_valid, 1'b0);
    chk1("t3_qhit_after", query_hit, 1'b0);
    tick();
    div_out_valid = 1'b0; #1;
    chk1("t3_flush_c2", div_flush, 1'b0);
    chk1("t3_no_wb_c2", wb_valid, 1'b0);
    chk1("t3_no_issue", div_issue, 1'b0);
    tick(); #1;
    chk1("t3_no_wb_c3", wb_valid, 1'b0);
    chk1("t3_busy_c3", busy, 1'b0);
    tick();

    // Flush coincident with ISSUE and with a push
    req(32'd120, 32'd3, 5'd12, 32'h77);
    tick();
    req(32'd130, 32'd3, 5'd13, 32'h78); flush = 1'b1; #1;
    chk1("t4_issue_suppressed", div_issue, 1'b0);
    chk1("t4_ready_flush", req_ready, 1'b0);
    chk1("t4_div_flush", div_flush, 1'b1);
    tick();
    req_valid = 1'b0; flush = 1'b0; #1;
    chk1("t4_busy_empty", busy, 1'b0);
    chk1("t4_no_issue_c1", div_issue, 1'b0);
    tick(); #1;
    chk1("t4_no_issue_c2", div_issue, 1'b0);
    chk1("t4_busy_c2", busy, 1'b0);
    tick();

    // Query: rd=0 never hits, rd=12 hits until writeback accept
    req(32'd50, 32'd5, 5'd0, 32'h88); query_rd = 5'd0; #1;
    chk1("t5_q0_push", query_hit, 1'b0);
    tick();
    req_valid = 1'b0; #1;
    chk1("t5_q0_queued", query_hit, 1'b0);
    run_op(32'd50, 32'h88, 32'd10);
    req(32'd12, 32'd1, 5'd12, 32'h99); query_rd = 5'd12; #1;
    chk1("t5_q12_not_stored", query_hit, 1'b0);
    tick();
    req_valid = 1'b0; #1;
    chk1("t5_q12_issue", query_hit, 1'b1);
    tick(); #1;
    chk1("t5_q12_run", query_hit, 1'b1);
    div_out_valid = 1'b1; div_result = 32'd12;
    tick();
    div_out_valid = 1'b0; #1;
    chk1("t5_q12_wb", query_hit, 1'b1);
    chk32("t5_wb_rd", 32'(wb_rd), 32'd12);
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0; #1;
    chk1("t5_q12_done", query_hit, 1'b0);
    tick();

    // Asynchronous reset in the middle of an op
    req(32'd33, 32'd3, 5'd3, 32'hAB); query_rd = 5'd3;
    tick();
    req_valid = 1'b0;
    tick(); #1;
    chk1("t6_busy_run", busy, 1'b1);
    rst = 1'b1; #1;
    chk1("t6_async_busy", busy, 1'b0);
    chk1("t6_async_qhit", query_hit, 1'b0);
    chk1("t6_async_flush", div_flush, 1'b0);
    chk1("t6_async_ready", req_ready, 1'b1);
    tick();
    rst = 1'b0;
    tick();
    req(32'd44, 32'd4, 5'd4, 32'hCD);
    tick();
    req_valid = 1'b0; #1;
    chk1("t6_issue_after_rst", div_issue, 1'b1);
    chk32("t6_issue_rs1", div_rs1, 32'd44);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/div_issue_ctrl.md
Name: div_issue_ctrl

Overview:
- Sequencing controller placed in front of the iterative divider in the EXU.
- Accepts divide ops from decode into a small in-order queue and issues them to the divider one at a time.
- Waits for the divider result, holds it in a writeback buffer until the writeback arbiter accepts it, and handles pipeline flush.
- Exposes an rd-pending query so decode can stall dependent instructions.

Parameters:
DEPTH, 2, queue entries (power of 2, >=2)
TAG_W, 32, width of instruction tag carried alongside each op

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
req_valid  in  1  decode presents a divide op
req_ready  out  1  queue can accept (not full and no flush)
req_rs1  in  32  dividend
req_rs2  in  32  divisor
req_rd  in  5  destination register
req_unsign  in  1  unsigned op
req_rem  in  1  remainder op (0 = quotient)
req_tag  in  TAG_W  instruction tag
flush  in  1  kill all ops held by this block
div_issue  out  1  one-cycle issue pulse to divider (drives legal&div)
div_rs1/div_rs2  out  32  operands, valid with div_issue
div_unsign/div_rem  out  1  op controls, valid with div_issue
div_rd  out  5  destination, valid with div_issue
div_flush  out  1  flush to divider
div_out_valid  in  1  divider result valid (cycle after finish)
div_result  in  32  divider result
wb_valid  out  1  result available for writeback
wb_ready  in  1  writeback arbiter accepts
wb_data  out  32  result
wb_rd  out  5  destination register
wb_tag  out  TAG_W  instruction tag
query_rd  in  5  decode source register to check
query_hit  out  1  query_rd pending in this block
busy  out  1  any op queued, in flight or awaiting writeback

Behaviour:
- Reset state: queue empty, FSM IDLE, all outputs 0 except req_ready=1.
- Queue:
  - FIFO of DEPTH entries holding {rs1, rs2, rd, unsign, rem, tag}; push when req_valid & req_ready.
  - req_ready = ~full & ~flush. Full means all DEPTH entries valid; a pop in the same cycle does not make the queue ready.
  - Pointers wrap modulo DEPTH; an occupancy counter of width log2(DEPTH)+1 resolves full/empty.
- FSM: IDLE, ISSUE, RUN, WB.
  - IDLE: if the queue is non-empty and flush=0, go to ISSUE.
  - ISSUE: assert div_issue for exactly one cycle with the head entry's fields, pop the head, latch rd/tag into inflight regs, go to RUN.
  - RUN: wait for div_out_valid. On arrival, capture div_result into the WB buffer and go to WB. No further div_issue until back in IDLE, which guarantees the divider has released.
  - WB: wb_valid=1 with buffer contents. On wb_ready, go to IDLE. Stable-while-valid: wb_data/wb_rd/wb_tag must not change while wb_valid=1 and wb_ready=0.
- Minimum latency: push at cycle T, issue at T+1, and the earliest writeback is div_out_valid+1.
- Back-to-back ops: the next issue occurs no earlier than 2 cycles after WB acceptance (WB to IDLE, then IDLE to ISSUE).
- Flush (any state):
  - Empty the queue; a same-cycle push is refused.
  - Drive div_flush=1 in that cycle and the next.
  - Discard the inflight op and the WB buffer; return to IDLE.
  - A div_out_valid in the flush cycle or the following cycle is ignored.
  - Flush in the ISSUE cycle: div_issue is still suppressed (div_issue = ISSUE & ~flush).
- query_hit (combinational): query_rd != 0 and it matches rd of any valid queue entry, the inflight op (RUN/ISSUE), or the WB buffer (WB).
- busy = ~empty | (state != IDLE).
- Unexpected div_out_valid outside RUN is ignored. An ASSERT_ON check flags it.
- Reset mid-operation: asynchronous return to the reset state in the same cycle; div_flush=0 during reset.

Test Plan:
- Single op: push rs1=100, rs2=7, rem=0, rd=5; model divider returns 14 -> div_issue at T+1, wb_valid with wb_data=14, wb_rd=5, held until wb_ready.
- Queue full: DEPTH=2, push 3 ops while divider busy -> req_ready=0 after 2nd push. 3rd accepted only after the first issue pop; ops issued in order with correct tags.
- WB backpressure: hold wb_ready=0 for 10 cycles -> wb_* stable, no new div_issue, query_hit=1 for the held rd.
- Flush in RUN with 1 queued op: flush pulse -> div_flush high 2 cycles, late div_out_valid ignored, wb_valid never asserts, busy=0 next cycle.
- Flush coincident with req_valid and with ISSUE -> req_ready=0, no div_issue, queue empty.
- Query: rd=0 queued, query_rd=0 -> query_hit=0. rd=12 queued, query_rd=12 -> query_hit=1 until WB accept.
